// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware FIFO with header tagging, fill flags and packet length tracking
//   clock, resetn (sync active-low), soft_reset (sync flush, keeps lfd_d)
//   write_enb/data_in/lfd_state: write side; the header tag is lfd_state delayed one cycle
//   read_enb/data_out: registered read data, held when no read is accepted
//   empty/full/almost_full/fill_count: combinational status from the pointers
//   pkt_remaining/pkt_done: words left in the current packet, pulse on its last word
//   wr_err: pulse after a write attempted while full
module router_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [AW:0]      fill_count,
  output logic [WIDTH-2:0] pkt_remaining,
  output logic             pkt_done,
  output logic             wr_err
);
  localparam logic [AW:0] ptr_one = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] af_lvl = AF_THRESH[AW:0];
  localparam logic [WIDTH-2:0] rem_one = {{(WIDTH-2){1'b0}}, 1'b1};
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             lfd_d, wr_ok, rd_ok;
  logic [WIDTH:0]   rd_word;
  logic [WIDTH-2:0] hdr_len;
  always_comb begin
    empty = wptr == rptr;
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    fill_count = wptr - rptr;
    almost_full = fill_count >= af_lvl;
    wr_ok = write_enb && !full;
    rd_ok = read_enb && !empty;
    rd_word = mem[rptr[AW-1:0]];
    // header length field plus one parity word
    hdr_len = {1'b0, rd_word[WIDTH-1:2]} + rem_one;
  end
  // storage is never cleared; resetting the pointers makes old entries unreachable
  always_ff @(posedge clock)
    if (resetn && !soft_reset && wr_ok) mem[wptr[AW-1:0]] <= {lfd_d, data_in};
  always_ff @(posedge clock)
    lfd_d <= resetn ? lfd_state : 1'b0;
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      wptr <= '0;
      rptr <= '0;
      data_out <= '0;
      pkt_remaining <= '0;
      pkt_done <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= write_enb && full;
      pkt_done <= 1'b0;
      if (wr_ok) wptr <= wptr + ptr_one;
      if (rd_ok) begin
        rptr <= rptr + ptr_one;
        data_out <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) pkt_remaining <= hdr_len;
        else if (pkt_remaining != '0) begin
          pkt_remaining <= pkt_remaining - rem_one;
          pkt_done <= pkt_remaining == rem_one;
        end
      end
    end
  end
endmodule
